// File: rtl/distribute_inject_fifo_seq.sv
// Injection stage feeding a chain of one-hot 1x2 distribute switches: FIFO plus one output register.
// Latency: a word pushed into an empty block is on o_valid after one edge. Backpressure: o_ready drops
// when the FIFO is full, regardless of a concurrent pop. Optional macro DIST_INJECT_DROP_ZERO_EN discards zero-mask words.
module distribute_inject_fifo_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODE   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_valid,
  input  logic [DATA_WIDTH-1:0]             i_data_bus,
  input  logic [NUM_NODE-1:0]               i_cmd,
  output logic                              o_ready,
  input  logic                              i_en,
  output logic                              o_valid,
  output logic [DATA_WIDTH-1:0]             o_data_bus,
  output logic [NUM_NODE-1:0]               o_cmd,
  output logic [$clog2(FIFO_DEPTH+2)-1:0]   o_count,
  output logic                              o_drop
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH+1);
  localparam int OCNT_W  = $clog2(FIFO_DEPTH+2);
  localparam int ENTRY_W = DATA_WIDTH + NUM_NODE;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count;

  logic push, accept, consume, reg_free, fifo_empty, pop, bypass, fifo_wr;

  assign o_ready    = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push       = i_valid && o_ready;
  assign consume    = o_valid && i_en;
  assign reg_free   = !o_valid || consume;
  assign fifo_empty = (fifo_count == '0);

`ifdef DIST_INJECT_DROP_ZERO_EN
  logic drop_now;
  assign drop_now = push && (i_cmd == '0);
  assign accept   = push && !drop_now;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_drop <= 1'b0;
    else      o_drop <= drop_now;
  end
`else
  assign accept = push;
  assign o_drop = 1'b0;
`endif

  // Register refill priority: FIFO head first, then bypass of the incoming word.
  assign pop     = reg_free && !fifo_empty;
  assign bypass  = reg_free && fifo_empty && accept;
  assign fifo_wr = accept && !bypass;

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= {i_data_bus, i_cmd};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(fifo_wr) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      o_cmd      <= '0;
    end else if (pop) begin
      o_valid               <= 1'b1;
      {o_data_bus, o_cmd}   <= mem[rd_ptr];
    end else if (bypass) begin
      o_valid    <= 1'b1;
      o_data_bus <= i_data_bus;
      o_cmd      <= i_cmd;
    end else if (consume) begin
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      o_cmd      <= '0;
    end
  end

  assign o_count = OCNT_W'(fifo_count) + OCNT_W'(o_valid);

endmodule

// File: tb/tb_distribute_inject_fifo_seq.sv
// Directed bench for distribute_inject_fifo_seq: vector table plus fill/drain, zero-mask and reset sequences.
module tb_distribute_inject_fifo_seq;

  localparam int DW = 32;
  localparam int NN = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic [DW-1:0] i_data_bus;
  logic [NN-1:0] i_cmd;
  logic          o_ready;
  logic          i_en;
  logic          o_valid;
  logic [DW-1:0] o_data_bus;
  logic [NN-1:0] o_cmd;
  logic [2:0]    o_count;
  logic          o_drop;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  distribute_inject_fifo_seq #(.DATA_WIDTH(DW), .NUM_NODE(NN), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus), .i_cmd(i_cmd),
    .o_ready(o_ready), .i_en(i_en), .o_valid(o_valid), .o_data_bus(o_data_bus),
    .o_cmd(o_cmd), .o_count(o_count), .o_drop(o_drop)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [NN-1:0] c, input logic en);
    i_valid    = v;
    i_data_bus = d;
    i_cmd      = c;
    i_en       = en;
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic [NN-1:0] c;
    logic          en;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [NN-1:0] e_cmd;
    logic [2:0]    e_count;
    logic          e_ready;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [DW-1:0] next_push, exp_next;
    logic          acc, cons;
    logic [DW-1:0] cons_data;
    int            cyc;

    vecs[0] = '{1'b1, 32'hA5A5A5A5, 8'b1000_0001, 1'b1, 1'b1, 32'hA5A5A5A5, 8'b1000_0001, 3'd1, 1'b1};
    vecs[1] = '{1'b0, 32'h0,        8'h00,        1'b1, 1'b0, 32'h0,        8'h00,        3'd0, 1'b1};
    vecs[2] = '{1'b1, 32'h11,       8'h01,        1'b0, 1'b1, 32'h11,       8'h01,        3'd1, 1'b1};
    vecs[3] = '{1'b1, 32'h22,       8'h02,        1'b0, 1'b1, 32'h11,       8'h01,        3'd2, 1'b1};
    vecs[4] = '{1'b1, 32'h33,       8'h04,        1'b1, 1'b1, 32'h22,       8'h02,        3'd2, 1'b1};
    vecs[5] = '{1'b0, 32'h0,        8'h00,        1'b1, 1'b1, 32'h33,       8'h04,        3'd1, 1'b1};
    vecs[6] = '{1'b0, 32'h0,        8'h00,        1'b0, 1'b1, 32'h33,       8'h04,        3'd1, 1'b1};
    vecs[7] = '{1'b0, 32'h0,        8'h00,        1'b1, 1'b0, 32'h0,        8'h00,        3'd0, 1'b1};

    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    step(); step();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data",  64'(o_data_bus), 64'd0);
    chk("rst_cmd",   64'(o_cmd), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_drop",  64'(o_drop), 64'd0);
    rst = 1'b1;

    // Table: bypass, clear, fill-behind, pop-with-push, hold.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].en);
      step();
      chk($sformatf("vec%0d_valid", i), 64'(o_valid),    64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_data", i),  64'(o_data_bus), 64'(vecs[i].e_data));
      chk($sformatf("vec%0d_cmd", i),   64'(o_cmd),      64'(vecs[i].e_cmd));
      chk($sformatf("vec%0d_count", i), 64'(o_count),    64'(vecs[i].e_count));
      chk($sformatf("vec%0d_ready", i), 64'(o_ready),    64'(vecs[i].e_ready));
    end

    // Fill with the chain stalled: 1 in the register, 4 in the FIFO, 6th refused.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'd100 + 32'(k), 8'h01, 1'b0);
      step();
    end
    chk("full_count", 64'(o_count), 64'd5);
    chk("full_ready", 64'(o_ready), 64'd0);
    chk("full_data",  64'(o_data_bus), 64'd100);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("frozen_valid", 64'(o_valid), 64'd1);
      chk("frozen_data",  64'(o_data_bus), 64'd100);
      chk("frozen_cmd",   64'(o_cmd), 64'h01);
      chk("frozen_count", 64'(o_count), 64'd5);
    end

    // Drain with continuous pushes: one word per cycle, strictly in order.
    next_push = 32'd105;
    exp_next  = 32'd100;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, next_push, 8'h01, 1'b1);
      acc = o_ready; cons = o_valid; cons_data = o_data_bus;
      step();
      if (acc) next_push++;
      chk("stream_consume", 64'(cons), 64'd1);
      chk("stream_order", 64'(cons_data), 64'(exp_next));
      exp_next++;
      if (k == 0) chk("ready_after_first_consume", 64'(o_ready), 64'd1);
      chk("stream_count", 64'(o_count), 64'd4);
    end
    i_valid = 1'b0;
    cyc = 0;
    while (o_valid && cyc < 20) begin
      cons_data = o_data_bus;
      step();
      chk("drain_order", 64'(cons_data), 64'(exp_next));
      exp_next++;
      cyc++;
    end
    chk("drain_done", 64'(o_valid), 64'd0);
    chk("drain_all_words", 64'(exp_next), 64'(next_push));
    chk("drain_count", 64'(o_count), 64'd0);

    // Zero-mask word between two real words, chain enabled.
    drive(1'b1, 32'h200, 8'h10, 1'b1);
    step();
    chk("zm_w1_data", 64'(o_data_bus), 64'h200);
    chk("zm_w1_cmd",  64'(o_cmd), 64'h10);
    drive(1'b1, 32'h201, 8'h00, 1'b1);
    step();
`ifdef DIST_INJECT_DROP_ZERO_EN
    chk("zm_drop_valid", 64'(o_valid), 64'd0);
    chk("zm_drop_pulse", 64'(o_drop), 64'd1);
    chk("zm_drop_count", 64'(o_count), 64'd0);
`else
    chk("zm_fwd_valid", 64'(o_valid), 64'd1);
    chk("zm_fwd_data",  64'(o_data_bus), 64'h201);
    chk("zm_fwd_cmd",   64'(o_cmd), 64'h00);
    chk("zm_no_drop",   64'(o_drop), 64'd0);
`endif
    drive(1'b1, 32'h202, 8'h20, 1'b1);
    step();
    chk("zm_w2_data", 64'(o_data_bus), 64'h202);
    chk("zm_w2_cmd",  64'(o_cmd), 64'h20);
    chk("zm_drop_end", 64'(o_drop), 64'd0);
    drive(1'b0, '0, '0, 1'b1);
    step();
    chk("zm_empty", 64'(o_count), 64'd0);

    // Asynchronous reset with three words buffered.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h300 + 32'(k), 8'h02, 1'b0);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    chk("pre_rst_count", 64'(o_count), 64'd3);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_data",  64'(o_data_bus), 64'd0);
    chk("arst_cmd",   64'(o_cmd), 64'd0);
    chk("arst_count", 64'(o_count), 64'd0);
    chk("arst_ready", 64'(o_ready), 64'd1);
    step();
    rst = 1'b1;
    drive(1'b1, 32'h3C3C, 8'h40, 1'b1);
    step();
    chk("post_rst_data",  64'(o_data_bus), 64'h3C3C);
    chk("post_rst_cmd",   64'(o_cmd), 64'h40);
    chk("post_rst_count", 64'(o_count), 64'd1);
    drive(1'b0, '0, '0, 1'b1);
    step();
    chk("post_rst_no_stale", 64'(o_valid), 64'd0);
    chk("post_rst_empty",    64'(o_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
